cdc_handshake_tx: RTL and testbench
===================================

# cdc_handshake_tx

Source-side end of the two-phase (toggle) request/acknowledge clock-domain crossing. It accepts a data word with a valid/ready handshake in the clk_i domain and launches it toward a destination domain. The data word is held on a stable register and the request line is toggled. The block then waits for the destination's toggled acknowledge, brought back through a cdc_sync instance, before it accepts the next word. It sits at the transmitting side of every multi-bit crossing whose receiving side is built from cdc_sync-synchronized request capture.

## Interface
Parameters:
- WIDTH, 32, data word width (≥1).
- RANK, 2, acknowledge synchronizer depth; passed to cdc_sync; legal range 2..4.
- RESET_VALUE, '0, reset value of cdc_data_o (WIDTH bits).
- TIMEOUT, 0, maximum WAIT_ACK cycles before err_o[1] is set; 0 disables the check; counter is 16 bits, legal range 0..65535.

Ports:
- clk_i  input  1  source-domain clock.
- rst_ni  input  1  reset, asynchronous, active-low; must be asserted together with the destination-side reset.
- valid_i  input  1  source word valid.
- ready_o  output  1  block can accept a word this cycle.
- data_i  input  WIDTH  source word.
- cdc_req_o  output  1  toggle request to destination; driven straight from a flop.
- cdc_data_o  output  WIDTH  held data to destination; driven straight from a flop.
- cdc_ack_i  input  1  toggle acknowledge from destination (asynchronous to clk_i).
- done_o  output  1  one-cycle pulse when a transfer's acknowledge has been received.
- err_o  output  2  sticky flags: [0] spurious acknowledge, [1] timeout.

## Operation
- The acknowledge is synchronized by cdc_sync configured as WIDTH 1, RESET 1, RANK RANK, RESET_VALUE 0. Its output is ack_s. No other logic samples cdc_ack_i.
- The state machine has two states: IDLE and WAIT_ACK. ready_o = (state == IDLE).
- **IDLE, valid_i high:**
  - cdc_data_o ← data_i.
  - req_q ← ~req_q.
  - Timeout counter ← 0.
  - Next state is WAIT_ACK.
- **IDLE, valid_i low:** hold all registers.
- **WAIT_ACK:**
  - When ack_s == req_q, the transfer is complete: next state is IDLE and done_o goes high for exactly one cycle (registered).
  - Otherwise the counter increments, saturating at its maximum value.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT, err_o[1] is set. The block stays in WAIT_ACK; there is no abort.
- cdc_data_o and cdc_req_o change only on the accept edge. cdc_data_o is stable for the whole time req_q ≠ ack_s.
- **Spurious acknowledge:** if ack_s != req_q while in IDLE, err_o[0] is set and the state is unchanged. When this happens at the same time as valid_i, the word is still accepted normally.
- Both err_o bits are sticky until reset.
- data_i and valid_i are ignored while ready_o is low.

## Timing
- Reset values:
  - ready_o = 1.
  - cdc_req_o = 0.
  - cdc_data_o = RESET_VALUE.
  - done_o = 0.
  - err_o = 0.
  - State is IDLE; counter is 0; synchronizer flops are 0.
- **Accept:** valid_i & ready_o sampled at edge E0. cdc_req_o and cdc_data_o update at E0, and ready_o is low after E0.
- **Acknowledge path:** cdc_ack_i toggles before edge Ea. ack_s updates after edge Ea+RANK-1. The FSM samples it at Ea+RANK: after that edge the state is IDLE, ready_o is 1 and done_o is 1 for one cycle.
- cdc_sync simulation randomness may add one cycle; benches must accept ±1 cycle.
- **Back-to-back:** a new word is accepted at the earliest one cycle after the completing edge, i.e. on the cycle where done_o is high.
- **Reset mid-transfer:** everything returns to reset values immediately (asynchronous reset). An in-flight word is lost, and no done_o pulse is generated.
- **Timeout:** err_o[1] is set after the edge at which the counter value equals TIMEOUT.

## Test plan
- **Reset defaults:** reset, then idle 10 cycles → ready_o=1, cdc_req_o=0, cdc_data_o=RESET_VALUE, done_o=0, err_o=0.
- **Single transfer:** RANK=2; send 0xDEADBEEF; a responder toggles cdc_ack_i 3 cycles after cdc_req_o rises.
  - cdc_data_o = 0xDEADBEEF held stable.
  - done_o pulses once 2 (±1) edges later.
  - ready_o returns high.
- **Back-to-back stream:** 100 random words with valid_i held high, RANK = 2, 3 and 4 → words arrive in order with no loss or duplication, 100 done_o pulses, and cdc_req_o ends at 0.
- **Spurious acknowledge:** toggle cdc_ack_i while IDLE → err_o = 2'b01 and remains set; no done_o pulse; the next transfer still completes.
- **Timeout:** TIMEOUT=20 with the responder silent → err_o[1] set 20 (±1) cycles after accept, ready_o stays 0; a late acknowledge then completes the transfer with done_o.
- **Reset mid-transfer:** assert rst_ni during WAIT_ACK with both sides reset → all outputs return to reset values and a following transfer completes normally.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase (toggle) req/ack crossing: holds a word on a flop,
// toggles the request and waits for the synchronized toggled acknowledge.

module cdc_sync #(
    parameter int unsigned           WIDTH       = 1,
    parameter bit                    RESET       = 1'b1,
    parameter int unsigned           RANK        = 2,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Entry 0 is the metastability-catching flop; the oldest entry is the output.
    logic [RANK-1:0][WIDTH-1:0] sync_q;

    if (RESET) begin : g_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= {RANK{RESET_VALUE}};
            end else begin
                sync_q <= {sync_q[RANK-2:0], d_i};
            end
        end
    end else begin : g_norst
        always_ff @(posedge clk_i) begin
            sync_q <= {sync_q[RANK-2:0], d_i};
        end
    end

    assign q_o = sync_q[RANK-1];

endmodule

module cdc_handshake_tx #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      RANK        = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      TIMEOUT     = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             cdc_req_o,
    output logic [WIDTH-1:0] cdc_data_o,
    input  logic             cdc_ack_i,
    output logic             done_o,
    output logic [1:0]       err_o
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_e;

    state_e           state_q, state_d;
    logic             req_q;
    logic [WIDTH-1:0] data_q;
    logic [15:0]      cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             ack_s;
    logic             ack_match;
    logic             accept;

    cdc_sync #(
        .WIDTH       (1),
        .RESET       (1'b1),
        .RANK        (RANK),
        .RESET_VALUE (1'b0)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cdc_ack_i),
        .q_o    (ack_s)
    );

    // Transfer is complete once the returned ack phase matches the request phase.
    assign ack_match = (ack_s == req_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ack_match) begin
                    err_d[0] = 1'b1;
                end
                if (valid_i) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    // No abort on timeout: the destination may still answer late.
                    if ((TIMEOUT != 0) && (cnt_d == TIMEOUT_CNT)) begin
                        err_d[1] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Launch registers move only on accept, so data is stable while req != ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= 1'b0;
            data_q <= RESET_VALUE;
        end else if (accept) begin
            req_q  <= ~req_q;
            data_q <= data_i;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign cdc_req_o  = req_q;
    assign cdc_data_o = data_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench: three DUTs (RANK 2/3/4), lane 0 also has TIMEOUT=20.
module tb_cdc_handshake_tx;

    localparam logic [31:0] RV       = 32'h1234_5678;
    localparam int          RESP_DLY = 3;

    logic             clk;
    logic             rst_n;
    logic [2:0]       valid;
    logic [2:0][31:0] data;
    logic [2:0]       ready;
    logic [2:0]       req;
    logic [2:0][31:0] cdo;
    logic [2:0]       done;
    logic [2:0][1:0]  err;
    logic [2:0]       resp_on;
    logic [2:0]       spur_tgl;
    wire  [2:0][15:0] done_cnt_w;
    wire  [2:0][15:0] rd_w;

    logic [31:0] exp_q [3][$];
    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : ln
        logic ack_l;
        int   done_cnt;
        int   rd;

        cdc_handshake_tx #(
            .WIDTH       (32),
            .RANK        (2 + g),
            .RESET_VALUE (RV),
            .TIMEOUT     ((g == 0) ? 20 : 0)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .valid_i    (valid[g]),
            .ready_o    (ready[g]),
            .data_i     (data[g]),
            .cdc_req_o  (req[g]),
            .cdc_data_o (cdo[g]),
            .cdc_ack_i  (ack_l),
            .done_o     (done[g]),
            .err_o      (err[g])
        );

        assign done_cnt_w[g] = 16'(done_cnt);
        assign rd_w[g]       = 16'(rd);

        // Destination model: echoes the request phase RESP_DLY cycles after it changes.
        initial begin : resp
            logic last;
            logic sp;
            int   cnt;
            ack_l = 1'b0;
            last  = 1'b0;
            sp    = 1'b0;
            cnt   = -1;
            forever begin
                @(negedge clk);
                if (spur_tgl[g] != sp) begin
                    sp    = spur_tgl[g];
                    ack_l = ~ack_l;
                end
                if (!rst_n) begin
                    ack_l = 1'b0;
                    last  = 1'b0;
                    cnt   = -1;
                end else begin
                    last = req[g];
                    if (cnt == 0) begin
                        ack_l = last;
                        cnt   = -1;
                    end else if (cnt > 0) begin
                        cnt--;
                    end else if (resp_on[g] && ack_l != last) begin
                        cnt = RESP_DLY - 1;
                    end
                end
            end
        end

        // Monitor: each request toggle must carry the next expected word, held until done.
        initial begin : mon
            logic        mlast;
            logic        busy;
            logic [31:0] held;
            mlast    = 1'b0;
            busy     = 1'b0;
            held     = '0;
            done_cnt = 0;
            rd       = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    mlast = 1'b0;
                    busy  = 1'b0;
                end else begin
                    if (done[g]) begin
                        done_cnt++;
                        check("done_busy", busy, 1);
                        check("held_data", cdo[g], held);
                        busy = 1'b0;
                    end
                    if (req[g] != mlast) begin
                        mlast = req[g];
                        check("launch_extra", rd < exp_q[g].size(), 1);
                        if (rd < exp_q[g].size()) begin
                            check("launch_data", cdo[g], exp_q[g][rd]);
                            rd++;
                        end
                        held = cdo[g];
                        busy = 1'b1;
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int l, input logic [31:0] w);
        int guard;
        guard    = 0;
        valid[l] = 1'b1;
        data[l]  = w;
        while (!ready[l] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready", guard < 100, 1);
        exp_q[l].push_back(w);
        @(negedge clk);
        valid[l] = 1'b0;
    endtask

    // Counts edges after the accept edge until done (or -1 on timeout).
    task automatic wait_done(input int l, output int cyc);
        cyc = 0;
        while (!done[l] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!done[l]) cyc = -1;
    endtask

    task automatic stream(input int l);
        int guard;
        for (int i = 0; i < 100; i++) begin
            valid[l] = 1'b1;
            data[l]  = $urandom;
            guard    = 0;
            while (!ready[l] && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                check("stream_stall", guard, 0);
                break;
            end
            exp_q[l].push_back(data[l]);
            @(negedge clk);
        end
        valid[l] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int base;
        int b0, b1, b2;
        n_checks = 0;
        n_fail   = 0;
        valid    = '0;
        data     = '0;
        resp_on  = '1;
        spur_tgl = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int l = 0; l < 3; l++) begin
            check("rst_ready", ready[l], 1);
            check("rst_req", req[l], 0);
            check("rst_data", cdo[l], RV);
            check("rst_done", done[l], 0);
            check("rst_err", err[l], 2'b00);
        end

        // Single transfer: ack 3 cycles after launch, +RANK sync, +1 FSM edge.
        send(0, 32'hDEAD_BEEF);
        check("single_busy", ready[0], 0);
        check("single_req", req[0], 1);
        wait_done(0, cyc);
        check_rng("single_latency", cyc, 5, 7);
        check("single_ready", ready[0], 1);
        check("single_data", cdo[0], 32'hDEAD_BEEF);
        @(negedge clk);
        check("single_pulse", done[0], 0);
        check("single_err", err[0], 2'b00);

        // Spurious acknowledge while idle.
        resp_on[0]  = 1'b0;
        base        = done_cnt_w[0];
        spur_tgl[0] = ~spur_tgl[0];
        repeat (6) @(negedge clk);
        check("spur_err", err[0], 2'b01);
        check("spur_nodone", done_cnt_w[0], base);
        check("spur_ready", ready[0], 1);
        repeat (5) @(negedge clk);
        check("spur_sticky", err[0], 2'b01);
        send(0, 32'h0BAD_F00D);
        wait_done(0, cyc);
        check_rng("spur_next_latency", cyc, 0, 2);
        @(negedge clk);
        check("spur_next_done", done_cnt_w[0], base + 1);
        check("spur_next_err", err[0], 2'b01);
        resp_on[0] = 1'b1;

        // Timeout with a silent responder, then a late acknowledge.
        resp_on[0] = 1'b0;
        send(0, 32'hCAFE_0001);
        cyc = 0;
        while (!err[0][1] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_rng("tmo_latency", cyc, 19, 21);
        check("tmo_ready", ready[0], 0);
        repeat (5) @(negedge clk);
        check("tmo_stay", ready[0], 0);
        check("tmo_data", cdo[0], 32'hCAFE_0001);
        resp_on[0] = 1'b1;
        wait_done(0, cyc);
        check("tmo_late_done", cyc >= 0, 1);
        check("tmo_late_ready", ready[0], 1);
        check("tmo_err", err[0], 2'b11);

        // Reset in the middle of a transfer.
        resp_on[0] = 1'b0;
        @(negedge clk);
        send(0, 32'h55AA_55AA);
        repeat (3) @(negedge clk);
        check("mid_busy", ready[0], 0);
        check("mid_data", cdo[0], 32'h55AA_55AA);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready[0], 1);
        check("mid_rst_req", req[0], 0);
        check("mid_rst_data", cdo[0], RV);
        check("mid_rst_done", done[0], 0);
        check("mid_rst_err", err[0], 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        resp_on[0] = 1'b1;
        @(negedge clk);
        send(0, 32'h600D_D00D);
        wait_done(0, cyc);
        check_rng("post_rst_latency", cyc, 5, 7);
        check("post_rst_err", err[0], 2'b00);

        // Back-to-back streams on all three ranks from a fresh reset.
        @(negedge clk);
        do_reset();
        b0 = done_cnt_w[0];
        b1 = done_cnt_w[1];
        b2 = done_cnt_w[2];
        fork
            stream(0);
            stream(1);
            stream(2);
        join
        cyc = 0;
        while ((done_cnt_w[0] != 16'(b0 + 100) || done_cnt_w[1] != 16'(b1 + 100) ||
                done_cnt_w[2] != 16'(b2 + 100)) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check("stream_done0", done_cnt_w[0], b0 + 100);
        check("stream_done1", done_cnt_w[1], b1 + 100);
        check("stream_done2", done_cnt_w[2], b2 + 100);
        for (int l = 0; l < 3; l++) begin
            check("stream_req_end", req[l], 0);
            check("stream_all_sent", rd_w[l], exp_q[l].size());
            check("stream_err", err[l], 2'b00);
            check("stream_ready", ready[l], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
